// File: rtl/fan_pkg.sv
// Shared constants and tree-geometry helpers for the forwarding adder network controller.
package fan_pkg;

  localparam logic [2:0] FAN_CMD_IDLE  = 3'b000;
  localparam logic [2:0] FAN_CMD_FWD   = 3'b001;
  localparam logic [2:0] FAN_CMD_DONE  = 3'b010;
  localparam logic [2:0] FAN_CMD_LDONE = 3'b011;
  localparam logic [2:0] FAN_CMD_RDONE = 3'b100;
  localparam logic [2:0] FAN_CMD_BDONE = 3'b101;

  typedef struct packed {
    int lo;
    int mid;
    int hi;
  } node_bounds_t;

  // First flat adder index used by tree level l.
  function automatic int off_lvl(input int l, input int num_pes);
    return num_pes - (num_pes >> l);
  endfunction

  function automatic node_bounds_t node_bounds(input int l, input int x);
    node_bounds_t b;
    b.lo  = x << (l + 1);
    b.mid = b.lo + (1 << l);
    b.hi  = b.lo + (2 << l) - 1;
    return b;
  endfunction

endpackage

// File: rtl/fan_node_dec.sv
// Combinational add-enable / command decode for one adder node (LVL, IDX) of the tree.
module fan_node_dec
  import fan_pkg::*;
#(
  parameter int NUM_PES  = 8,
  parameter int LOG2_PES = 3,
  parameter int LVL      = 0,
  parameter int IDX      = 0
) (
  input  logic [NUM_PES*LOG2_PES-1:0] vn,
  output logic                        add,
  output logic [2:0]                  cmd
);

  localparam node_bounds_t NB = node_bounds(LVL, IDX);
  localparam int LO  = NB.lo;
  localparam int MID = NB.mid;
  localparam int HI  = NB.hi;
  localparam bit HAS_LN = (LO != 0);
  localparam bit HAS_RN = (HI != NUM_PES - 1);
  // Neighbour indices are clamped so edge nodes never select outside vn.
  localparam int LN = HAS_LN ? LO - 1 : LO;
  localparam int RN = HAS_RN ? HI + 1 : HI;

  logic [LOG2_PES-1:0] id_ln;
  logic [LOG2_PES-1:0] id_mm1;
  logic [LOG2_PES-1:0] id_mid;
  logic [LOG2_PES-1:0] id_rn;
  logic                enclosed;
  logic [2:0]          leaf_cmd;
  logic                unused_bits;

  assign id_ln  = vn[LN*LOG2_PES +: LOG2_PES];
  assign id_mm1 = vn[(MID-1)*LOG2_PES +: LOG2_PES];
  assign id_mid = vn[MID*LOG2_PES +: LOG2_PES];
  assign id_rn  = vn[RN*LOG2_PES +: LOG2_PES];
  assign unused_bits = ^vn;

  if (LVL == 0) begin : g_leaf
    logic [LOG2_PES-1:0] id_lo;
    logic [LOG2_PES-1:0] id_hi;
    logic                lo_single;
    logic                hi_single;

    assign id_lo     = vn[LO*LOG2_PES +: LOG2_PES];
    assign id_hi     = vn[HI*LOG2_PES +: LOG2_PES];
    assign lo_single = !HAS_LN || (id_ln != id_lo);
    assign hi_single = !HAS_RN || (id_rn != id_hi);

    always_comb begin
      case ({lo_single, hi_single})
        2'b11:   leaf_cmd = FAN_CMD_BDONE;
        2'b10:   leaf_cmd = FAN_CMD_LDONE;
        2'b01:   leaf_cmd = FAN_CMD_RDONE;
        default: leaf_cmd = FAN_CMD_IDLE;
      endcase
    end
  end else begin : g_inner
    assign leaf_cmd = FAN_CMD_IDLE;
  end

  always_comb begin
    add      = (id_mm1 == id_mid);
    enclosed = (!HAS_LN || (id_ln != id_mid)) && (!HAS_RN || (id_rn != id_mid));
    cmd      = FAN_CMD_IDLE;
    if (add) begin
      cmd = enclosed ? FAN_CMD_DONE : FAN_CMD_FWD;
    end else begin
      cmd = leaf_cmd;
    end
  end

endmodule

// File: rtl/fan_ctrl_pipe.sv
// FAN controller: VN delay line, per-node decode, diagonally staged per-level control and valid.
module fan_ctrl_pipe
  import fan_pkg::*;
#(
  parameter int NUM_PES  = 8,
  parameter int LOG2_PES = 3,
  parameter int VN_DLY   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PES*LOG2_PES-1:0] i_vn,
  input  logic                        i_stationary,
  input  logic                        i_data_valid,
  input  logic                        i_stall,
  output logic [NUM_PES-2:0]          o_reduction_add,
  output logic [3*(NUM_PES-1)-1:0]    o_reduction_cmd,
  output logic                        o_reduction_valid,
  output logic [LOG2_PES:0]           o_num_vn
);

  localparam int VW = NUM_PES * LOG2_PES;
  localparam logic [LOG2_PES:0] CNT_ONE = 1;

  logic                     accept;
  logic [VW-1:0]            vn_dly [VN_DLY];
  logic [VN_DLY-1:0]        v_dly;
  logic [VW-1:0]            dec_vn;
  logic                     dec_v;
  logic [NUM_PES-2:0]       dec_add;
  logic [3*(NUM_PES-1)-1:0] dec_cmd;
  logic [LOG2_PES:0]        vn_cnt;
  logic [LOG2_PES:0]        num_vn_q;
  logic [LOG2_PES:0]        vld_q;

  assign accept = i_data_valid && !i_stationary && !i_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VN_DLY; i++) vn_dly[i] <= '0;
      v_dly <= '0;
    end else if (!i_stall) begin
      vn_dly[0] <= i_vn;
      v_dly[0]  <= accept;
      for (int i = 1; i < VN_DLY; i++) begin
        vn_dly[i] <= vn_dly[i-1];
        v_dly[i]  <= v_dly[i-1];
      end
    end
  end

  assign dec_vn = vn_dly[VN_DLY-1];
  assign dec_v  = v_dly[VN_DLY-1];

  always_comb begin
    vn_cnt = CNT_ONE;
    for (int p = 0; p < NUM_PES - 1; p++) begin
      if (dec_vn[p*LOG2_PES +: LOG2_PES] != dec_vn[(p+1)*LOG2_PES +: LOG2_PES]) begin
        vn_cnt = vn_cnt + CNT_ONE;
      end
    end
  end

  // Level l gets l+1 stages so its control meets the data one level per cycle later.
  for (genvar l = 0; l < LOG2_PES; l++) begin : g_lvl
    localparam int W   = NUM_PES >> (l + 1);
    localparam int OFF = off_lvl(l, NUM_PES);
    localparam int D   = l + 1;

    logic [W-1:0]   add_q [D];
    logic [3*W-1:0] cmd_q [D];

    for (genvar x = 0; x < W; x++) begin : g_node
      fan_node_dec #(
        .NUM_PES (NUM_PES),
        .LOG2_PES(LOG2_PES),
        .LVL     (l),
        .IDX     (x)
      ) u_dec (
        .vn (dec_vn),
        .add(dec_add[OFF+x]),
        .cmd(dec_cmd[3*(OFF+x) +: 3])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < D; k++) begin
          add_q[k] <= '0;
          cmd_q[k] <= '0;
        end
      end else if (!i_stall) begin
        add_q[0] <= dec_v ? dec_add[OFF +: W] : '0;
        cmd_q[0] <= dec_v ? dec_cmd[3*OFF +: 3*W] : '0;
        for (int k = 1; k < D; k++) begin
          add_q[k] <= add_q[k-1];
          cmd_q[k] <= cmd_q[k-1];
        end
      end
    end

    assign o_reduction_add[OFF +: W]     = add_q[D-1];
    assign o_reduction_cmd[3*OFF +: 3*W] = cmd_q[D-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_vn_q <= '0;
      vld_q    <= '0;
    end else if (!i_stall) begin
      num_vn_q <= dec_v ? vn_cnt : '0;
      vld_q    <= {vld_q[LOG2_PES-1:0], dec_v};
    end
  end

  assign o_num_vn          = num_vn_q;
  assign o_reduction_valid = vld_q[LOG2_PES];

endmodule

// File: tb/tb_fan_ctrl_pipe.sv
// Scoreboard bench for fan_ctrl_pipe: 8-PE default instance and a 16-PE, VN_DLY=1 instance.
module tb_fan_ctrl_pipe;

  typedef struct packed {
    logic        v;
    logic [14:0] add;
    logic [44:0] cmd;
    logic [4:0]  nvn;
  } smp_t;

  typedef struct {
    smp_t s;
    int   vedge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] vn8;
  logic        sta8, dv8, st8;
  logic [6:0]  add8;
  logic [20:0] cmd8;
  logic        v8;
  logic [3:0]  nv8;
  logic [63:0] vn16;
  logic        dv16, st16;
  logic [14:0] add16;
  logic [44:0] cmd16;
  logic        v16;
  logic [4:0]  nv16;

  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;
  logic adv [2];
  exp_t q [2][$];
  smp_t h [2][$];
  int   npe [2] = '{8, 16};
  int   lg  [2] = '{3, 4};
  smp_t cur [2];
  smp_t got;
  exp_t e;
  logic [23:0] tv [4];
  smp_t        te [4];

  fan_ctrl_pipe u8 (
    .clk(clk), .rst(rst), .i_vn(vn8), .i_stationary(sta8), .i_data_valid(dv8), .i_stall(st8),
    .o_reduction_add(add8), .o_reduction_cmd(cmd8), .o_reduction_valid(v8), .o_num_vn(nv8)
  );

  fan_ctrl_pipe #(.NUM_PES(16), .LOG2_PES(4), .VN_DLY(1)) u16 (
    .clk(clk), .rst(rst), .i_vn(vn16), .i_stationary(1'b0), .i_data_valid(dv16), .i_stall(st16),
    .o_reduction_add(add16), .o_reduction_cmd(cmd16), .o_reduction_valid(v16), .o_num_vn(nv16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ecnt   <= ecnt + 1;
    adv[0] <= !rst && !st8;
    adv[1] <= !rst && !st16;
  end

  task automatic chk(input string nm, input logic [65:0] g, input logic [65:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, g, w);
    end
  endtask

  function automatic smp_t mk(input logic [14:0] a, input logic [44:0] c, input logic [4:0] n);
    return {1'b1, a, c, n};
  endfunction

  // Reassemble one vector's tree outputs from the per-level diagonal in the history.
  function automatic smp_t diag(input smp_t hh[$], input int n, input int lgv);
    smp_t r;
    int   last;
    r    = '0;
    last = hh.size() - 1;
    for (int l = 0; l < lgv; l++) begin
      int off;
      int idx;
      off = n - (n >> l);
      idx = last - (lgv - l);
      for (int x = 0; x < (n >> (l + 1)); x++) begin
        r.add[off+x]          = hh[idx].add[off+x];
        r.cmd[3*(off+x) +: 3] = hh[idx].cmd[3*(off+x) +: 3];
      end
    end
    r.nvn = hh[last-lgv].nvn;
    r.v   = hh[last].v;
    return r;
  endfunction

  always @(negedge clk) begin
    cur[0] = {v8, 8'b0, add8, 24'b0, cmd8, 1'b0, nv8};
    cur[1] = {v16, add16, cmd16, nv16};
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        h[i].delete();
      end else if (!adv[i]) begin
        if (h[i].size() > 0) chk($sformatf("stall_hold%0d", i), 66'(cur[i]), 66'(h[i][h[i].size()-1]));
      end else begin
        h[i].push_back(cur[i]);
        if (h[i].size() > 8) void'(h[i].pop_front());
        if (cur[i].v) begin
          if (q[i].size() == 0 || h[i].size() < lg[i] + 1) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid%0d got=1 want=0 edge=%0d", i, ecnt);
          end else begin
            e   = q[i].pop_front();
            got = diag(h[i], npe[i], lg[i]);
            chk($sformatf("valid_edge%0d", i), 66'(ecnt), 66'(e.vedge));
            chk($sformatf("tree_out%0d", i), 66'(got), 66'(e.s));
          end
        end
      end
      if (!rst && q[i].size() > 0 && ecnt > q[i][0].vedge) begin
        total++;
        bad++;
        $display("FAIL timeout%0d got=no_valid want=valid_by_edge_%0d", i, q[i][0].vedge);
        void'(q[i].pop_front());
      end
    end
  end

  task automatic put8(input int k, input int vedge);
    vn8 = tv[k];
    dv8 = 1'b1;
    q[0].push_back('{s: te[k], vedge: vedge});
  endtask

  task automatic chk_zero8(input string nm);
    chk({nm, "_add"}, 66'(add8), 66'(0));
    chk({nm, "_cmd"}, 66'(cmd8), 66'(0));
    chk({nm, "_valid"}, 66'(v8), 66'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = {3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    te[0] = mk(15'b1110101, {24'b0, 21'b010_001_010_100_001_000_001}, 5'd3);
    tv[1] = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    te[1] = mk(15'b0000000, {24'b0, 21'b000_000_000_101_101_101_101}, 5'd8);
    tv[2] = 24'h0;
    te[2] = mk(15'b1111111, {24'b0, 21'b010_001_001_001_001_001_001}, 5'd1);
    tv[3] = {3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0};
    te[3] = mk(15'b0111010, {24'b0, 21'b000_010_010_001_011_001_011}, 5'd4);

    vn8 = '0; sta8 = 1'b0; dv8 = 1'b0; st8 = 1'b0;
    vn16 = '0; dv16 = 1'b0; st16 = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero8("reset");
    chk("reset_nvn", 66'(nv8), 66'(0));
    chk("reset_add16", 66'(add16), 66'(0));
    rst = 1'b0;
    @(negedge clk);

    // Four 4-PE VNs on the 16-PE instance.
    vn16 = 64'h3333222211110000;
    dv16 = 1'b1;
    q[1].push_back('{s: mk(15'h0fff, {9'b0, {4{3'b010}}, {8{3'b001}}}, 5'd4), vedge: ecnt + 6});
    @(negedge clk);
    dv16 = 1'b0;
    repeat (10) @(negedge clk);

    put8(0, ecnt + 6);
    @(negedge clk);
    dv8 = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back vectors.
    put8(1, ecnt + 6);
    @(negedge clk);
    put8(2, ecnt + 6);
    @(negedge clk);
    put8(3, ecnt + 6);
    @(negedge clk);
    dv8 = 1'b0;
    repeat (10) @(negedge clk);

    // Three stalled edges right after the first vector; the second is held by the source.
    put8(0, ecnt + 9);
    @(negedge clk);
    put8(1, ecnt + 9);
    st8 = 1'b1;
    repeat (3) @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    dv8 = 1'b0;
    repeat (12) @(negedge clk);

    // Stationary loads and invalid samples never reach the tree.
    vn8  = tv[0];
    sta8 = 1'b1;
    dv8  = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 2) begin
        sta8 = 1'b0;
        dv8  = 1'b0;
      end
      chk_zero8($sformatf("bubble%0d", c));
    end

    // Asynchronous reset with two vectors in flight.
    put8(3, ecnt + 6);
    @(negedge clk);
    put8(0, ecnt + 6);
    @(negedge clk);
    dv8 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    q[0].delete();
    #1;
    chk_zero8("async_rst");
    chk("async_rst_nvn", 66'(nv8), 66'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    put8(2, ecnt + 6);
    @(negedge clk);
    dv8 = 1'b0;
    repeat (10) @(negedge clk);

    chk("drain8", 66'(q[0].size()), 66'(0));
    chk("drain16", 66'(q[1].size()), 66'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fan_ctrl_pipe.md
Name: fan_ctrl_pipe

Overview:
- Next-generation Forwarding Adder Network (FAN) controller, generalised to any power-of-two NUM_PES.
- Turns a per-PE virtual-neuron (VN) id vector into per-adder add-enables and VN commands for every tree level.
- Outputs are diagonally staged so that level l control lines up with the data arriving at level l.
- Adds a stall (freeze) input, a programmable VN-delay depth and a VN-count output, none of which the previous controller had.

Parameters:
- NUM_PES, 8: number of PE leaves. Power of two, at least 4.
- LOG2_PES, 3: log2(NUM_PES). Also the number of tree levels.
- VN_DLY, 2: register stages on i_vn before level-0 control is generated. Must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_vn  in  NUM_PES*LOG2_PES  VN id per PE; PE p occupies [p*LOG2_PES +: LOG2_PES]
- i_stationary  in  1  vector is a stationary load; no reduction is produced
- i_data_valid  in  1  input vector valid
- i_stall  in  1  freeze the whole pipeline
- o_reduction_add  out  NUM_PES-1  add enable per adder
- o_reduction_cmd  out  3*(NUM_PES-1)  3-bit command per adder
- o_reduction_valid  out  1  tree output valid
- o_num_vn  out  LOG2_PES+1  number of VNs in the reducing vector

Behaviour:
- Adder indexing:
  - Node (l,x) uses bit OFF(l)+x, where OFF(l) = NUM_PES - NUM_PES>>l; the cmd field is 3 bits at the same index.
  - Node spans L = x*2^(l+1), M = L+2^l, R = L+2^(l+1)-1.
- Input contract: VN ids are non-decreasing across PEs, so each VN is one contiguous run. Non-monotone input gives undefined cmd values but must never lock up the pipeline.
- Sampling: a vector is accepted on a rising edge where i_data_valid=1, i_stationary=0 and i_stall=0. All other samples are treated as bubbles, which carry add=0, cmd=000 and valid=0.
- add(l,x) = (vn[M-1] == vn[M]).
- enclosed(l,x) = (L==0 or vn[L-1] != vn[M]) and (R==NUM_PES-1 or vn[R+1] != vn[M]).
- Level-0 cmd:
  - If add: 010 when enclosed, otherwise 001.
  - If not add: 101 when both PE 2x and PE 2x+1 are single-PE VNs; 011 when only the left is; 100 when only the right is; otherwise 000.
  - A PE counts as single when its out-of-node neighbour differs or does not exist.
- Level-l (l ≥ 1) cmd: if add, 010 when enclosed, otherwise 001; if not add, 000.
- Command codes: 000 idle, 001 forward, 010 sum done, 011 left done, 100 right done, 101 both done.
- o_num_vn = 1 + count of p with vn[p] != vn[p+1]. Bubbles give 0.
- Latency, counted as cycles after the accepting edge:
  - Level-l add/cmd are registered and visible after VN_DLY+1+l edges.
  - o_num_vn is visible together with level 0.
  - o_reduction_valid asserts for 1 cycle after VN_DLY+LOG2_PES+1 edges.
  - With the defaults: level 0 at edge 3, level 1 at 4, level 2 at 5, valid at 6.
- Throughput: one vector per cycle with no gaps required.
- Stall: while i_stall=1, every register holds (the VN delay line, diagonal stages and valid shift) and all outputs hold their values. On release, the pipeline resumes exactly where it stopped; only stalled cycles are added to the latency.
- Reset: asynchronous. All registers and all outputs go to 0 immediately, including in the middle of an operation. Vectors in flight are discarded, and no valid is produced for them after release.
- Simultaneous i_stall with a valid input: the input is not accepted, and the source must hold it.

Decomposition:
- Package fan_pkg holds:
  - the cmd code constants (FAN_CMD_IDLE, FWD, DONE, LDONE, RDONE, BDONE);
  - a function off_lvl(l, NUM_PES);
  - a function for the node L/M/R bounds.
- Sub-module fan_node_dec: combinational per-node decode, taking the vn vector plus l and x and producing add and cmd. It is instantiated NUM_PES-1 times by a generate loop; the parent owns all registers.

Test Plan:
- Default parameters, ids PE0..7 = 0,0,0,1,1,1,1,2, valid -> add = 7'b1110101 and cmd per node (level 0: 001,000,001,100; level 1: 010,001; level 2: 010); levels appear at edges 3/4/5, valid at edge 6, o_num_vn = 3.
- All ids distinct 0..7 -> level-0 cmd all 101, add all 0, level ≥1 cmd 000, o_num_vn = 8.
- All ids 0 -> all add = 1, level 0/1 cmd 001, top cmd 010, o_num_vn = 1.
- Back-to-back vectors with a 3-cycle i_stall inserted at edge 2 -> outputs frozen for 3 cycles, valid at edge 9, second vector exactly 1 cycle later.
- i_stationary=1 with valid, and i_data_valid=0 -> no valid ever asserted, and all add/cmd stay 0.
- rst asserted at edge 4 with 2 vectors in flight -> outputs 0 within the same cycle; after release no valid appears until a new vector is accepted.
- NUM_PES=16, LOG2_PES=4, VN_DLY=1, ids four VNs of 4 PEs each -> level-1 cmd all 010, level 2/3 add 0, valid at edge 6.
